// File: rtl/csr_ctrl.sv
// CSR read-modify-write sequencer: IDLE->READ->EXEC->WRITE, writes land 3 edges after accept; req_ready low and stall high while busy.
// Define CSR_RO_CHECK_EN to fault writes to read-only CSRs (addr[11:10] == 2'b11) instead of performing them.
module csr_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic        rs1_is_zero,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rd_addr,
  input  logic        flush,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] alu_result,
  output logic [2:0]  op_sel,
  output logic [1:0]  alu_op,
  output logic [11:0] csr_raddr,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        rd_we,
  output logic [4:0]  rd_waddr,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_e;

  state_e      state_q;
  logic [2:0]  f3_q;
  logic [11:0] addr_q;
  logic [4:0]  rd_q;
  logic        rs1z_q;
  logic [31:0] old_q;
  logic [31:0] new_q;
  logic        req_ready_q;
  logic        stall_q;
  logic [2:0]  op_sel_q;
  logic [1:0]  alu_op_q;
  logic [11:0] csr_raddr_q;
  logic        csr_we_q;
  logic [11:0] csr_waddr_q;
  logic        rd_we_q;
  logic [4:0]  rd_waddr_q;
  logic [31:0] rd_data_q;
  logic        illegal_q;

  logic        accept_d;
  logic [2:0]  op_sel_d;
  logic [1:0]  alu_op_d;
  logic        csr_wr_d;
  logic        ro_fault_d;

  always_comb begin
    accept_d = req_valid && !flush && (funct3[1:0] != 2'b00);
    op_sel_d = 3'd0;
    alu_op_d = 2'd0;
    case (f3_q)
      3'b001:         op_sel_d = 3'd1;
      3'b101:         op_sel_d = 3'd2;
      3'b010, 3'b011: op_sel_d = 3'd3;
      3'b110, 3'b111: op_sel_d = 3'd4;
      default:        op_sel_d = 3'd0;
    endcase
    case (f3_q[1:0])
      2'b10:   alu_op_d = 2'd1;
      2'b11:   alu_op_d = 2'd2;
      default: alu_op_d = 2'd0;
    endcase
    // Set/clear with a zero operand is a pure read and must not touch the CSR.
    csr_wr_d = (f3_q[1:0] == 2'b01) || !rs1z_q;
`ifdef CSR_RO_CHECK_EN
    ro_fault_d = (addr_q[11:10] == 2'b11) && csr_wr_d;
`else
    ro_fault_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      f3_q        <= 3'd0;
      addr_q      <= 12'd0;
      rd_q        <= 5'd0;
      rs1z_q      <= 1'b0;
      old_q       <= 32'd0;
      new_q       <= 32'd0;
      req_ready_q <= 1'b1;
      stall_q     <= 1'b0;
      op_sel_q    <= 3'd0;
      alu_op_q    <= 2'd0;
      csr_raddr_q <= 12'd0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= 12'd0;
      rd_we_q     <= 1'b0;
      rd_waddr_q  <= 5'd0;
      rd_data_q   <= 32'd0;
      illegal_q   <= 1'b0;
    end else begin
      csr_we_q  <= 1'b0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      op_sel_q  <= 3'd0;
      alu_op_q  <= 2'd0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            f3_q        <= funct3;
            addr_q      <= csr_addr;
            rd_q        <= rd_addr;
            rs1z_q      <= rs1_is_zero;
            csr_raddr_q <= csr_addr;
            req_ready_q <= 1'b0;
            stall_q     <= 1'b1;
            state_q     <= READ;
          end
        end
        READ: begin
          old_q       <= csr_rdata;
          csr_raddr_q <= 12'd0;
          if (flush) begin
            req_ready_q <= 1'b1;
            stall_q     <= 1'b0;
            state_q     <= IDLE;
          end else begin
            op_sel_q <= op_sel_d;
            alu_op_q <= alu_op_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (flush) begin
            req_ready_q <= 1'b1;
            stall_q     <= 1'b0;
            state_q     <= IDLE;
          end else begin
            new_q       <= alu_result;
            csr_we_q    <= csr_wr_d && !ro_fault_d;
            csr_waddr_q <= addr_q;
            rd_we_q     <= (rd_q != 5'd0) && !ro_fault_d;
            rd_waddr_q  <= rd_q;
            rd_data_q   <= old_q;
            illegal_q   <= ro_fault_d;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          // Commit is already on the outputs; flush here cannot retract it.
          new_q       <= 32'd0;
          csr_waddr_q <= 12'd0;
          rd_waddr_q  <= 5'd0;
          rd_data_q   <= 32'd0;
          req_ready_q <= 1'b1;
          stall_q     <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign stall     = stall_q;
  assign op_sel    = op_sel_q;
  assign alu_op    = alu_op_q;
  assign csr_raddr = csr_raddr_q;
  assign csr_we    = csr_we_q;
  assign csr_waddr = csr_waddr_q;
  assign csr_wdata = new_q;
  assign rd_we     = rd_we_q;
  assign rd_waddr  = rd_waddr_q;
  assign rd_data   = rd_data_q;
  assign illegal   = illegal_q;

endmodule
